fir_sched: RTL and testbench

Two-channel micro-op scheduler that time-shares the single register-file FIR datapath (op/src1/src2/dest, 16×17-bit registers, one ext_data1 and one ext_data2 port) between two independent sample streams and a coefficient loader. It captures request pulses, arbitrates between them and issues a fixed, non-preemptible micro-op sequence per grant. It also reports completion, per-channel sample counts and arithmetic errors. It sits between the synchronised strobes and the datapath, in place of the single-channel controller.

---
 rtl/fir_sched_pkg.sv | 76 +++++++
 rtl/fir_sched_if.sv | 28 ++
 rtl/fir_rr_arb.sv | 36 +++
 rtl/fir_sched.sv | 150 +++++++++++++++
 tb/tb_fir_sched.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types, register map and micro-op table for the two-channel FIR scheduler.
package fir_sched_pkg;

    localparam int NTAPS   = 4;
    localparam int CIDX_W  = $clog2(NTAPS);
    localparam int SEQ_LEN = 11;
    localparam logic [3:0] K_LAST = 4'(SEQ_LEN - 1);

    localparam logic [3:0] R_OUT       = 4'd0;
    localparam logic [3:0] R_ACC       = 4'd1;
    localparam logic [3:0] R_TMP       = 4'd2;
    localparam logic [3:0] R_CH0_BASE  = 4'd3;
    localparam logic [3:0] R_CH1_BASE  = 4'd7;
    localparam logic [3:0] R_COEF_BASE = 4'd11;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_COPY  = 3'd1,
        OP_LOAD1 = 3'd2,
        OP_LOAD2 = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_MUL   = 3'd6
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COEFF,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    typedef struct packed {
        op_t        op;
        logic [3:0] src1;
        logic [3:0] src2;
        logic [3:0] dest;
    } uop_t;

    function automatic uop_t mk_uop(input op_t o, input logic [3:0] s1,
                                    input logic [3:0] s2, input logic [3:0] d);
        uop_t u;
        u.op   = o;
        u.src1 = s1;
        u.src2 = s2;
        u.dest = d;
        return u;
    endfunction

    function automatic logic is_arith(input op_t o);
        return (o == OP_ADD) || (o == OP_SUB) || (o == OP_MUL);
    endfunction

    // Shift the tap line oldest-first so no tap is overwritten before it is copied.
    function automatic uop_t sample_uop(input logic [3:0] k, input logic ch);
        logic [3:0] s0;
        uop_t       u;
        s0 = ch ? R_CH1_BASE : R_CH0_BASE;
        case (k)
            4'd0:    u = mk_uop(OP_COPY,  s0 + 4'd2, 4'd0, s0 + 4'd3);
            4'd1:    u = mk_uop(OP_COPY,  s0 + 4'd1, 4'd0, s0 + 4'd2);
            4'd2:    u = mk_uop(OP_COPY,  s0,        4'd0, s0 + 4'd1);
            4'd3:    u = mk_uop(OP_LOAD1, 4'd0,      4'd0, s0);
            4'd4:    u = mk_uop(OP_MUL,   s0,        R_COEF_BASE,        R_ACC);
            4'd5:    u = mk_uop(OP_MUL,   s0 + 4'd1, R_COEF_BASE + 4'd1, R_TMP);
            4'd6:    u = mk_uop(OP_ADD,   R_ACC,     R_TMP,              R_ACC);
            4'd7:    u = mk_uop(OP_MUL,   s0 + 4'd2, R_COEF_BASE + 4'd2, R_TMP);
            4'd8:    u = mk_uop(OP_ADD,   R_ACC,     R_TMP,              R_ACC);
            4'd9:    u = mk_uop(OP_MUL,   s0 + 4'd3, R_COEF_BASE + 4'd3, R_TMP);
            4'd10:   u = mk_uop(OP_ADD,   R_ACC,     R_TMP,              R_OUT);
            default: u = mk_uop(OP_NOP,   4'd0,      4'd0,               4'd0);
        endcase
        return u;
    endfunction

endpackage

// File: rtl/fir_sched_if.sv
// Strobe inputs and datapath control outputs of the FIR scheduler.
interface fir_sched_if;
    import fir_sched_pkg::*;

    logic [1:0] dr;
    logic       lc;
    logic       overflow;
    op_t        op;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dest;
    logic       sample_sel;
    logic       modwait;
    logic [1:0] out_valid;
    logic [1:0] cnt_up;
    logic       err;
    logic       overrun;

    modport master (
        input  dr, lc, overflow,
        output op, src1, src2, dest, sample_sel, modwait, out_valid, cnt_up, err, overrun
    );

    modport slave (
        output dr, lc, overflow,
        input  op, src1, src2, dest, sample_sel, modwait, out_valid, cnt_up, err, overrun
    );
endinterface

// File: rtl/fir_rr_arb.sv
// Two-requester round-robin arbiter with a priority override and a grant enable.
module fir_rr_arb (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       en,
    output logic       gnt_prio,
    output logic [1:0] gnt
);

    logic ptr;  // channel favoured on the next tie

    always_comb begin
        gnt_prio = en & prio;
        gnt      = 2'b00;
        if (en && !prio) begin
            if (req == 2'b11) begin
                gnt[ptr] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr <= 1'b0;
        end else if (gnt[0]) begin
            ptr <= 1'b1;
        end else if (gnt[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/fir_sched.sv
// Two-channel micro-op scheduler for the shared register-file FIR datapath.
// Duplicate-request detection is built only when FIR_SCHED_OVERRUN_EN is defined.
//
// state  | meaning
// IDLE   | datapath idle, arbitrate pending requests
// COEFF  | one LOAD2 into the next coefficient register
// SAMPLE | 11-step shift/multiply/accumulate for the granted channel
// DONE   | result in r0, pulse out_valid/cnt_up for that channel
module fir_sched
    import fir_sched_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    fir_sched_if.master bus
);

    state_t            state, state_nx;
    logic [3:0]        k, k_nx;
    logic              gch;
    logic [CIDX_W-1:0] cidx;
    logic [1:0]        pend_dr, gnt;
    logic              pend_lc, gnt_lc;
    logic              seq_ovf, ovf_hit, err_q;
    uop_t              uop;
    logic              modwait;
    logic [1:0]        out_valid;

    fir_rr_arb u_arb (
        .clk      (clk),
        .n_rst    (n_rst),
        .req      (pend_dr),
        .prio     (pend_lc),
        .en       (state == ST_IDLE),
        .gnt_prio (gnt_lc),
        .gnt      (gnt)
    );

    // A pulse coinciding with the grant re-arms the flag for another pass.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pend_dr <= 2'b00;
            pend_lc <= 1'b0;
        end else begin
            pend_dr <= (pend_dr & ~gnt) | bus.dr;
            pend_lc <= (pend_lc & ~gnt_lc) | bus.lc;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
            k     <= 4'd0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        k_nx      = 4'd0;
        uop       = '0;
        modwait   = 1'b0;
        out_valid = 2'b00;
        case (state)
            ST_IDLE: begin
                if (gnt_lc) begin
                    state_nx = ST_COEFF;
                end else if (|gnt) begin
                    state_nx = ST_SAMPLE;
                end
            end
            ST_COEFF: begin
                uop      = mk_uop(OP_LOAD2, 4'd0, 4'd0, R_COEF_BASE + 4'(cidx));
                modwait  = 1'b1;
                state_nx = ST_IDLE;
            end
            ST_SAMPLE: begin
                uop     = sample_uop(k, gch);
                modwait = 1'b1;
                if (k == K_LAST) begin
                    state_nx = ST_DONE;
                end else begin
                    k_nx = k + 4'd1;
                end
            end
            ST_DONE: begin
                modwait        = 1'b1;
                out_valid[gch] = 1'b1;
                state_nx       = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign ovf_hit = (state == ST_SAMPLE) && is_arith(uop.op) && bus.overflow;

    // err updates on the edge into DONE so it is valid alongside out_valid.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gch     <= 1'b0;
            cidx    <= '0;
            seq_ovf <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (|gnt) begin
                gch     <= gnt[1];
                seq_ovf <= 1'b0;
            end else if (ovf_hit) begin
                seq_ovf <= 1'b1;
            end
            if (state == ST_COEFF) begin
                cidx <= cidx + CIDX_W'(1);
            end
            if (state == ST_SAMPLE && k == K_LAST) begin
                err_q <= seq_ovf | ovf_hit;
            end
        end
    end

`ifdef FIR_SCHED_OVERRUN_EN
    logic overrun_q;
    logic dup;

    assign dup = (|(bus.dr & pend_dr & ~gnt)) | (bus.lc & pend_lc & ~gnt_lc);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overrun_q <= 1'b0;
        end else if (dup) begin
            overrun_q <= 1'b1;
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.op         = uop.op;
    assign bus.src1       = uop.src1;
    assign bus.src2       = uop.src2;
    assign bus.dest       = uop.dest;
    assign bus.sample_sel = gch;
    assign bus.modwait    = modwait;
    assign bus.out_valid  = out_valid;
    assign bus.cnt_up     = out_valid;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_fir_sched.sv
// Self-checking bench for fir_sched: register-file plant, cycle model and directed tests.
module tb_fir_sched;
    import fir_sched_pkg::*;

`ifdef FIR_SCHED_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    localparam int K_IDLE  = 0;
    localparam int K_COEFF = 1;
    localparam int K_SAMP  = 2;
    localparam int K_DONE  = 3;

    typedef struct {
        int op;
        int s1;
        int s2;
        int d;
        int kind;
        int ch;
        int k;
    } rec_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    fir_sched_if bus ();
    fir_sched dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;

    // Datapath plant: executes whatever the scheduler issues.
    int rf[16];
    int samp[2];
    int coef_in;

    always @(posedge clk) begin
        case (bus.op)
            OP_COPY:  rf[bus.dest] <= rf[bus.src1];
            OP_LOAD1: rf[bus.dest] <= samp[bus.sample_sel];
            OP_LOAD2: rf[bus.dest] <= coef_in;
            OP_ADD:   rf[bus.dest] <= rf[bus.src1] + rf[bus.src2];
            OP_SUB:   rf[bus.dest] <= rf[bus.src1] - rf[bus.src2];
            OP_MUL:   rf[bus.dest] <= rf[bus.src1] * rf[bus.src2];
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [22:0] act_vec();
        return {bus.op, bus.src1, bus.src2, bus.dest, bus.sample_sel, bus.modwait,
                bus.out_valid, bus.cnt_up, bus.err, bus.overrun};
    endfunction

    function automatic rec_t mk(input int op, input int s1, input int s2, input int d,
                                input int kind, input int ch, input int k);
        rec_t r;
        r.op = op; r.s1 = s1; r.s2 = s2; r.d = d; r.kind = kind; r.ch = ch; r.k = k;
        return r;
    endfunction

    // Cycle model: each grant expands into the list of cycles it must occupy.
    rec_t       q[$];
    rec_t       cur;
    logic [1:0] m_pend_dr, m_clr, m_ov;
    logic       m_pend_lc, m_clr_lc, m_sel, m_err, m_ovf, m_over, m_dup, m_mw;
    int         m_pref, m_cidx, m_g;
    int         m_coef[4];
    int         m_hist[2][4];
    logic [22:0] m_exp;

    task automatic push_sample(input int g);
        int b;
        b = (g == 1) ? 7 : 3;
        q.push_back(mk(1, b + 2, 0, b + 3, K_SAMP, g, 0));
        q.push_back(mk(1, b + 1, 0, b + 2, K_SAMP, g, 1));
        q.push_back(mk(1, b,     0, b + 1, K_SAMP, g, 2));
        q.push_back(mk(2, 0,     0, b,     K_SAMP, g, 3));
        q.push_back(mk(6, b,     11, 1,    K_SAMP, g, 4));
        q.push_back(mk(6, b + 1, 12, 2,    K_SAMP, g, 5));
        q.push_back(mk(4, 1,     2,  1,    K_SAMP, g, 6));
        q.push_back(mk(6, b + 2, 13, 2,    K_SAMP, g, 7));
        q.push_back(mk(4, 1,     2,  1,    K_SAMP, g, 8));
        q.push_back(mk(6, b + 3, 14, 2,    K_SAMP, g, 9));
        q.push_back(mk(4, 1,     2,  0,    K_SAMP, g, 10));
        q.push_back(mk(0, 0,     0,  0,    K_DONE, g, 11));
    endtask

    function automatic int fir(input int ch);
        int y;
        y = 0;
        for (int i = 0; i < 4; i++) y += m_coef[i] * m_hist[ch][i];
        return y;
    endfunction

    always @(negedge clk) begin
        if (!n_rst) begin
            q.delete();
            m_pend_dr = 2'b00; m_pend_lc = 1'b0; m_pref = 0; m_cidx = 0;
            m_sel = 1'b0; m_err = 1'b0; m_ovf = 1'b0; m_over = 1'b0;
            chk("reset_hold", 32'(act_vec()), 32'd0);
        end else begin
            m_clr = 2'b00;
            m_clr_lc = 1'b0;
            if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = mk(0, 0, 0, 0, K_IDLE, 0, 0);
                if (m_pend_lc) begin
                    m_clr_lc = 1'b1;
                    q.push_back(mk(3, 0, 0, 11 + m_cidx, K_COEFF, 0, 0));
                    m_cidx = (m_cidx + 1) % 4;
                end else if (m_pend_dr != 2'b00) begin
                    m_g = (m_pend_dr == 2'b11) ? m_pref : (m_pend_dr[1] ? 1 : 0);
                    m_clr[m_g] = 1'b1;
                    m_pref = 1 - m_g;
                    push_sample(m_g);
                end
            end
            case (cur.kind)
                K_COEFF: m_coef[cur.d - 11] = coef_in;
                K_SAMP: begin
                    m_sel = cur.ch[0];
                    if (cur.k == 0) m_ovf = 1'b0;
                    if (cur.k == 3) begin
                        for (int i = 3; i > 0; i--) m_hist[cur.ch][i] = m_hist[cur.ch][i - 1];
                        m_hist[cur.ch][0] = samp[cur.ch];
                    end
                    if (cur.op >= 4) m_ovf = m_ovf | bus.overflow;
                end
                K_DONE: begin
                    m_sel = cur.ch[0];
                    m_err = m_ovf;
                end
                default: ;
            endcase
            m_mw = (cur.kind != K_IDLE);
            m_ov = (cur.kind == K_DONE) ? (2'b01 << cur.ch) : 2'b00;
            m_exp = {3'(cur.op), 4'(cur.s1), 4'(cur.s2), 4'(cur.d), m_sel, m_mw,
                     m_ov, m_ov, m_err, m_over};
            chk("cycle", 32'(act_vec()), 32'(m_exp));
            if (cur.kind == K_DONE) chk("outreg", rf[0], fir(cur.ch));
            m_dup = (|(bus.dr & m_pend_dr & ~m_clr)) | (bus.lc & m_pend_lc & ~m_clr_lc);
            m_pend_dr = (m_pend_dr & ~m_clr) | bus.dr;
            m_pend_lc = (m_pend_lc & ~m_clr_lc) | bus.lc;
            m_over = m_over | (m_dup & OVR_EN);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] d, input logic l);
        bus.dr = d;
        bus.lc = l;
        cyc(1);
        bus.dr = 2'b00;
        bus.lc = 1'b0;
    endtask

    task automatic wait_ov(input int ch, output int lat);
        lat = 0;
        while (!bus.out_valid[ch] && lat < 60) begin
            cyc(1);
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, mw_cnt, lc_dest, n0, n1;
        bus.dr = 2'b00;
        bus.lc = 1'b0;
        bus.overflow = 1'b0;
        samp[0] = 0;
        samp[1] = 0;
        coef_in = 0;

        cyc(2);
        chk("reset_outs", 32'(act_vec()), 32'd0);
        n_rst = 1'b1;
        cyc(2);

        // Coefficients 1..4, then a fifth load that wraps to r11.
        for (int v = 1; v <= 4; v++) begin
            coef_in = v;
            pulse(2'b00, 1'b1);
            cyc(2);
        end
        for (int i = 0; i < 4; i++) chk("coef_reg", rf[11 + i], 32'(i + 1));
        coef_in = 1;
        pulse(2'b00, 1'b1);
        mw_cnt = 0;
        lc_dest = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            if (bus.modwait) mw_cnt++;
            if (bus.op == OP_LOAD2) lc_dest = int'(bus.dest);
        end
        chk("lc_modwait_cycles", mw_cnt, 1);
        chk("lc_wrap_dest", lc_dest, 11);

        // ch0 sample 5 into cleared taps.
        samp[0] = 5;
        pulse(2'b01, 1'b0);
        wait_ov(0, lat);
        chk("ch0_latency", lat + 1, 13);
        chk("ch0_outreg", rf[0], 5);
        chk("ch0_cnt_up", 32'(bus.cnt_up), 32'd1);
        cyc(2);

        // Overflow on k6 of a ch1 sequence.
        samp[1] = 4;
        pulse(2'b10, 1'b0);
        cyc(7);
        bus.overflow = 1'b1;
        cyc(1);
        bus.overflow = 1'b0;
        wait_ov(1, lat);
        chk("err_set", 32'(bus.err), 32'd1);
        cyc(3);
        chk("err_hold", 32'(bus.err), 32'd1);

        // Simultaneous lc and both channels: COEFF, ch0, ch1.
        samp[0] = 2;
        samp[1] = 3;
        coef_in = 9;
        pulse(2'b11, 1'b1);
        wait_ov(0, lat);
        chk("simul_ch0_latency", lat + 1, 15);
        chk("simul_sel0", 32'(bus.sample_sel), 32'd0);
        chk("err_clear", 32'(bus.err), 32'd0);
        wait_ov(1, lat);
        chk("simul_gap", lat, 13);
        chk("simul_sel1", 32'(bus.sample_sel), 32'd1);
        cyc(2);

        // Duplicate ch0 requests while ch1 runs.
        pulse(2'b10, 1'b0);
        cyc(3);
        pulse(2'b01, 1'b0);
        cyc(2);
        pulse(2'b01, 1'b0);
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (bus.out_valid[0]) n0++;
            if (bus.out_valid[1]) n1++;
        end
        chk("dup_ch0_runs", n0, 1);
        chk("dup_ch1_runs", n1, 1);
        chk("overrun", 32'(bus.overrun), 32'(OVR_EN));

        // Asynchronous reset at k5 of a ch1 sequence.
        samp[1] = 6;
        pulse(2'b10, 1'b0);
        cyc(6);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_reset", 32'(act_vec()), 32'd0);
        cyc(2);
        n_rst = 1'b1;
        cyc(1);
        samp[1] = 7;
        pulse(2'b10, 1'b0);
        wait_ov(1, lat);
        chk("post_reset_latency", lat + 1, 13);
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
